// File: rtl/uart_frame_packer.sv
// Wraps each FRAME_LEN-word frame as SYNC0 SYNC1 cnt_lo cnt_hi payload(LSB first) checksum; define UART_FRAME_PACKER_CRC8_EN for CRC-8 (poly 0x07).
// Latency: first header byte one cycle after in_valid in idle; one bubble cycle per word load.
// Backpressure: out_ready low freezes state and holds out_data; in_ready only rises in S_LOAD, never with out_valid.
module uart_frame_packer #(
    parameter int         WORD_WIDTH = 16,
    parameter int         FRAME_LEN  = 768,
    parameter logic [7:0] SYNC0      = 8'hA5,
    parameter logic [7:0] SYNC1      = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt
);

    localparam int BPW = WORD_WIDTH / 8;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WIW = $clog2(FRAME_LEN + 1);
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPW - 1);
    localparam logic [WIW-1:0] LAST_WORD = WIW'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_PAYLOAD,
        S_CKSUM
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              hdr_idx_q, hdr_idx_d;
    logic [BIW-1:0]          byte_idx_q, byte_idx_d;
    logic [WIW-1:0]          word_idx_q, word_idx_d;
    logic [WORD_WIDTH-1:0]   word_q, word_d;
    logic [7:0]              cksum_q, cksum_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [7:0]              out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;

    logic                    out_xfer;
    logic                    in_xfer;
    logic [WORD_WIDTH-1:0]   word_shifted;

    assign out_xfer = out_valid_q & out_ready;
    assign in_xfer  = in_valid & in_ready_q;

    // Running check value folded one transmitted byte at a time.
    function automatic logic [7:0] cksum_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef UART_FRAME_PACKER_CRC8_EN
        logic [7:0] c;
        c = acc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
`else
        return acc + b;
`endif
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (out_xfer && hdr_idx_q == 2'd3) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_xfer) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (out_xfer && byte_idx_q == LAST_BYTE) begin
                    state_d = (word_idx_q == LAST_WORD) ? S_CKSUM : S_LOAD;
                end
            end
            S_CKSUM: begin
                if (out_xfer) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        hdr_idx_d    = hdr_idx_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        word_d       = word_q;
        cksum_d      = cksum_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                hdr_idx_d = 2'd0;
            end
            S_HDR: begin
                if (out_xfer) begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    // Only the counter bytes (index 2, 3) enter the check value.
                    if (hdr_idx_q[1]) begin
                        cksum_d = cksum_step(cksum_q, out_data_q);
                    end
                end
            end
            S_LOAD: begin
                if (in_xfer) begin
                    word_d     = in_data;
                    byte_idx_d = '0;
                end
            end
            S_PAYLOAD: begin
                if (out_xfer) begin
                    cksum_d = cksum_step(cksum_q, out_data_q);
                    if (byte_idx_q == LAST_BYTE) begin
                        byte_idx_d = '0;
                        word_idx_d = word_idx_q + 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            S_CKSUM: begin
                if (out_xfer) begin
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    frame_done_d = 1'b1;
                    cksum_d      = 8'h00;
                    word_idx_d   = '0;
                end
            end
            default: ;
        endcase

        word_shifted = word_d >> {byte_idx_d, 3'b000};

        out_valid_d = (state_d == S_HDR) || (state_d == S_PAYLOAD) || (state_d == S_CKSUM);
        in_ready_d  = (state_d == S_LOAD);
        busy_d      = (state_d != S_IDLE);

        case (state_d)
            S_HDR: begin
                case (hdr_idx_d)
                    2'd0:    out_data_d = SYNC0;
                    2'd1:    out_data_d = SYNC1;
                    2'd2:    out_data_d = frame_cnt_q[7:0];
                    default: out_data_d = frame_cnt_q[15:8];
                endcase
            end
            S_PAYLOAD: out_data_d = word_shifted[7:0];
            S_CKSUM:   out_data_d = cksum_d;
            default:   out_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_idx_q    <= 2'd0;
            byte_idx_q   <= '0;
            word_idx_q   <= '0;
            word_q       <= '0;
            cksum_q      <= 8'h00;
            frame_cnt_q  <= 16'h0000;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            hdr_idx_q    <= hdr_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            word_q       <= word_d;
            cksum_q      <= cksum_d;
            frame_cnt_q  <= frame_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Bench for uart_frame_packer: random words and ready patterns against a packet-level reference model.
module tb_uart_frame_packer;

    localparam int WW  = 16;
    localparam int FL  = 2;
    localparam int BPW = WW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [WW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_frame_packer #(
        .WORD_WIDTH(WW),
        .FRAME_LEN (FL),
        .SYNC0     (8'hA5),
        .SYNC1     (8'h5A)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt)
    );

    logic [WW-1:0] in_q[$];
    logic [WW-1:0] words[$];
    logic [7:0]    got[$];
    logic [7:0]    exp_q[$];
    int            done_cnt;
    int            popped;
    int            hold_left;
    int            stall_left;
    bit            rand_rdy;
    bit            prev_wait;
    logic [7:0]    prev_data;
    logic [15:0]   model_fc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check byte over the message as long polynomial division (CRC build) or a plain byte sum.
    function automatic logic [7:0] ref_cksum(input logic [7:0] body[$]);
`ifdef UART_FRAME_PACKER_CRC8_EN
        logic [8:0] rem;
        logic [7:0] b;
        rem = 9'd0;
        for (int i = 0; i <= body.size(); i++) begin
            b = (i < body.size()) ? body[i] : 8'h00;
            for (int k = 7; k >= 0; k--) begin
                rem = {rem[7:0], b[k]};
                if (rem[8]) rem = rem ^ 9'h107;
            end
        end
        return rem[7:0];
`else
        int s;
        s = 0;
        foreach (body[i]) s = (s + int'(body[i])) % 256;
        return 8'(s);
`endif
    endfunction

    task automatic build_expected(input logic [15:0] fc, input logic [WW-1:0] ws[$]);
        logic [7:0]    body[$];
        logic [WW-1:0] w;
        body = {};
        body.push_back(fc[7:0]);
        body.push_back(fc[15:8]);
        foreach (ws[i]) begin
            w = ws[i];
            for (int j = 0; j < BPW; j++) body.push_back(w[8*j +: 8]);
        end
        exp_q = {8'hA5, 8'h5A};
        foreach (body[i]) exp_q.push_back(body[i]);
        exp_q.push_back(ref_cksum(body));
    endtask

    // One clock: drive inputs, check handshake rules, record transfers, then advance to edge+1.
    task automatic cyc();
        if (stall_left > 0 && popped == 1) begin
            in_valid = 1'b0;
            stall_left--;
            if (stall_left == 0) begin
                check("stall_in_ready", in_ready, 1);
                check("stall_out_valid", out_valid, 0);
                check("stall_busy", busy, 1);
            end
        end else begin
            in_valid = (in_q.size() > 0);
            in_data  = in_valid ? in_q[0] : '0;
        end
        if (hold_left > 0 && out_valid && got.size() == 1) begin
            out_ready = 1'b0;
            hold_left--;
            check("hold_sync1", out_data, 8'h5A);
        end else begin
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("in_rdy_with_out_vld", in_ready & out_valid, 0);
        if (prev_wait) begin
            check("held_valid", out_valid, 1);
            check("held_data", out_data, prev_data);
        end
        prev_wait = out_valid && !out_ready;
        prev_data = out_data;
        if (out_valid && out_ready) got.push_back(out_data);
        if (in_valid && in_ready) begin
            void'(in_q.pop_front());
            popped++;
        end
        if (frame_done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input logic [WW-1:0] ws[$]);
        int tgt;
        tgt    = done_cnt + 1;
        in_q   = ws;
        got    = {};
        popped = 0;
        build_expected(model_fc, ws);
        for (int c = 0; c < 2000 && done_cnt < tgt; c++) cyc();
        repeat (3) cyc();
        model_fc = model_fc + 16'd1;
        check({tag, "_done_pulses"}, done_cnt, tgt);
        check({tag, "_frame_cnt"}, frame_cnt, model_fc);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_len"}, got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            check({tag, "_byte", $sformatf("%0d", i)}, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
        end
    endtask

    task automatic rand_words();
        words = {};
        for (int i = 0; i < FL; i++) words.push_back(WW'($urandom));
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        rand_rdy   = 1'b0;
        hold_left  = 0;
        stall_left = 0;
        done_cnt   = 0;
        popped     = 0;
        prev_wait  = 1'b0;
        prev_data  = 8'h00;
        model_fc   = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_cnt", frame_cnt, 16'h0000);
        rst = 1'b0;

        // Basic packet, ready held high.
        words = {16'h1234, 16'hABCD};
        run_frame("basic", words);
`ifndef UART_FRAME_PACKER_CRC8_EN
        check("basic_cksum_lit", (got.size() > 8) ? got[8] : 8'hxx, 8'hBE);
`endif

        // Same words with random ready and a 5-cycle hold on SYNC1.
        rand_rdy  = 1'b1;
        hold_left = 5;
        run_frame("bp", words);
        check("bp_hold_done", hold_left, 0);

        // Input stall after the first word.
        rand_rdy   = 1'b0;
        stall_left = 20;
        rand_words();
        run_frame("stall", words);
        check("stall_done", stall_left, 0);

        // Random words and ready.
        rand_rdy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            rand_words();
            run_frame("rand", words);
        end

        // Frame counter wrap via backdoor.
        rand_rdy = 1'b0;
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_cnt_q;
        @(posedge clk);
        #1;
        model_fc = 16'hFFFF;
        check("wrap_preset", frame_cnt, 16'hFFFF);
        rand_words();
        run_frame("wrap", words);
        rand_words();
        run_frame("after_wrap", words);
        check("after_wrap_lo", (got.size() > 3) ? got[2] : 8'hxx, 8'h00);
        check("after_wrap_hi", (got.size() > 3) ? got[3] : 8'hxx, 8'h00);

        // Reset after the 6th byte transfers.
        rand_words();
        in_q   = words;
        got    = {};
        popped = 0;
        for (int c = 0; c < 200 && got.size() < 6; c++) cyc();
        check("mid_reached", got.size(), 6);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frame_cnt", frame_cnt, 16'h0000);
        check("mid_rst_in_ready", in_ready, 0);
        rst       = 1'b0;
        model_fc  = 16'h0000;
        prev_wait = 1'b0;
        in_q      = {};
        rand_words();
        run_frame("post_rst", words);
        check("post_rst_b0", (got.size() > 3) ? got[0] : 8'hxx, 8'hA5);
        check("post_rst_b1", (got.size() > 3) ? got[1] : 8'hxx, 8'h5A);
        check("post_rst_b2", (got.size() > 3) ? got[2] : 8'hxx, 8'h00);
        check("post_rst_b3", (got.size() > 3) ? got[3] : 8'hxx, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
